// File: rtl/eg_seq.sv
// Time-multiplexed envelope-generator sequencer: per-slot phase/level/LSB storage,
// global envelope counter and phase transitions. Optional macro: JT12_EG_INSTANT_ATTACK_EN.
module eg_seq #(
  parameter int NSLOTS = 24,
  parameter int EGDIV  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        keyon,
  input  logic [4:0]  ar,
  input  logic [4:0]  d1r,
  input  logic [4:0]  d2r,
  input  logic [3:0]  rr,
  input  logic [3:0]  sl,
  input  logic [9:0]  eg_pure,
  input  logic        cnt_lsb,
  output logic [4:0]  slot,
  output logic        zero,
  output logic        attack,
  output logic [4:0]  base_rate,
  output logic [14:0] eg_cnt,
  output logic [9:0]  eg_in,
  output logic        cnt_in,
  output logic [1:0]  phase
);

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY1  = 2'd1,
    DECAY2  = 2'd2,
    RELEASE = 2'd3
  } phase_t;

  localparam int DW = (EGDIV > 1) ? $clog2(EGDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(EGDIV - 1);
  localparam logic [4:0]    SLOT_LAST = 5'(NSLOTS - 1);

  // cen qualifies every state update: one slot is read, recomputed and written back per enabled edge.
  logic [4:0]    slot_q;
  logic [DW-1:0] div_q;
  logic [14:0]   eg_cnt_q;

  // Storage is sized for the full 5-bit slot index; only NSLOTS entries are ever visited.
  phase_t     phase_mem [0:31];
  logic [9:0] level_mem [0:31];
  logic       keyed_mem [0:31];
  logic       lsb_mem   [0:31];

  phase_t     cur_phase;
  logic       cur_keyed;
  logic       kon_edge;
  logic [4:0] slx;
  phase_t     nxt_phase;
  logic [9:0] nxt_level;

  always_comb begin
    cur_phase = phase_mem[slot_q];
    cur_keyed = keyed_mem[slot_q];
    kon_edge  = keyon & ~cur_keyed;
    slx       = (sl == 4'hF) ? 5'h1F : {1'b0, sl};
    nxt_phase = cur_phase;
    nxt_level = eg_pure;
    if (kon_edge) begin
      nxt_phase = ATTACK;
`ifdef JT12_EG_INSTANT_ATTACK_EN
      if (ar == 5'd31) begin
        nxt_phase = DECAY1;
        nxt_level = 10'd0;
      end
`endif
    end else if (!keyon && cur_phase != RELEASE) begin
      nxt_phase = RELEASE;
    end else if (cur_phase == ATTACK && eg_pure == 10'd0) begin
      nxt_phase = DECAY1;
    end else if (cur_phase == DECAY1 && eg_pure[9:5] >= slx) begin
      nxt_phase = DECAY2;
    end
  end

  always_comb begin
    base_rate = {rr, 1'b1};
    case (cur_phase)
      ATTACK:  base_rate = ar;
      DECAY1:  base_rate = d1r;
      DECAY2:  base_rate = d2r;
      default: base_rate = {rr, 1'b1};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= 5'd0;
      div_q    <= '0;
      eg_cnt_q <= 15'd0;
      for (int i = 0; i < 32; i++) begin
        phase_mem[i] <= RELEASE;
        level_mem[i] <= 10'h3FF;
        keyed_mem[i] <= 1'b0;
        lsb_mem[i]   <= 1'b0;
      end
    end else if (cen) begin
      phase_mem[slot_q] <= nxt_phase;
      level_mem[slot_q] <= nxt_level;
      keyed_mem[slot_q] <= keyon;
      lsb_mem[slot_q]   <= cnt_lsb;
      if (slot_q == SLOT_LAST) begin
        slot_q <= 5'd0;
        if (div_q == DIV_LAST) begin
          div_q    <= '0;
          eg_cnt_q <= eg_cnt_q + 15'd1;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end else begin
        slot_q <= slot_q + 5'd1;
      end
    end
  end

  assign slot   = slot_q;
  assign zero   = (slot_q == 5'd0);
  assign attack = (cur_phase == ATTACK);
  assign phase  = cur_phase;
  assign eg_cnt = eg_cnt_q;
  assign eg_in  = level_mem[slot_q];
  assign cnt_in = lsb_mem[slot_q];

endmodule

// File: tb/tb_eg_seq.sv
// Randomized bench for eg_seq against a slot-array reference model; a second
// small instance (2 slots, divider 1) runs long enough to wrap the envelope counter.
module tb_eg_seq;

  localparam int NS = 24;
  localparam int ED = 3;

  logic        clk = 1'b0;
  logic        rst, cen, keyon, cnt_lsb, rst2;
  logic [4:0]  ar, d1r, d2r;
  logic [3:0]  rr, sl;
  logic [9:0]  eg_pure;
  logic [4:0]  slot, base_rate;
  logic        zero, attack, cnt_in;
  logic [14:0] eg_cnt;
  logic [9:0]  eg_in;
  logic [1:0]  phase;

  logic [4:0]  slot2, base_rate2;
  logic        zero2, attack2, cnt_in2;
  logic [14:0] eg_cnt2;
  logic [9:0]  eg_in2;
  logic [1:0]  phase2;

  always #5 clk = ~clk;

  eg_seq #(.NSLOTS(NS), .EGDIV(ED)) dut (
    .clk(clk), .rst(rst), .cen(cen), .keyon(keyon), .ar(ar), .d1r(d1r), .d2r(d2r),
    .rr(rr), .sl(sl), .eg_pure(eg_pure), .cnt_lsb(cnt_lsb), .slot(slot), .zero(zero),
    .attack(attack), .base_rate(base_rate), .eg_cnt(eg_cnt), .eg_in(eg_in),
    .cnt_in(cnt_in), .phase(phase)
  );

  eg_seq #(.NSLOTS(2), .EGDIV(1)) dut2 (
    .clk(clk), .rst(rst2), .cen(1'b1), .keyon(1'b0), .ar(5'd0), .d1r(5'd0), .d2r(5'd0),
    .rr(4'd0), .sl(4'd0), .eg_pure(10'h3FF), .cnt_lsb(1'b0), .slot(slot2), .zero(zero2),
    .attack(attack2), .base_rate(base_rate2), .eg_cnt(eg_cnt2), .eg_in(eg_in2),
    .cnt_in(cnt_in2), .phase(phase2)
  );

  int n_cmp = 0;
  int n_err = 0;

  int         m_phase [32];
  logic [9:0] m_level [32];
  bit         m_keyed [32];
  bit         m_lsb   [32];
  bit         key_state [32];
  int         ticks, ticks2;
  bit         model_valid = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int slx_of(input logic [3:0] s);
    return (s == 4'hF) ? 31 : int'(s);
  endfunction

  task automatic drive_inputs(input bit hold_rst, input bit rand_ctrl);
    int s;
    logic [4:0] sx;
    logic [4:0] lo;
    logic [9:0] tmp;
    s = ticks % NS;
    if ($urandom_range(0, 7) == 0) key_state[s] = !key_state[s];
    keyon   = key_state[s];
    ar      = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
    d1r     = 5'($urandom_range(0, 31));
    d2r     = 5'($urandom_range(0, 31));
    rr      = 4'($urandom_range(0, 15));
    sl      = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
    cnt_lsb = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0: eg_pure = 10'd0;
      1: eg_pure = 10'($urandom_range(0, 1023));
      2: begin
        sx  = 5'(slx_of(sl));
        lo  = 5'($urandom_range(0, 31));
        tmp = {sx, lo};
        if ($urandom_range(0, 1) == 1 && tmp >= 10'd32) tmp = tmp - 10'd32;
        eg_pure = tmp;
      end
      default: eg_pure = 10'h3FF;
    endcase
    rst  = hold_rst || (rand_ctrl && $urandom_range(0, 599) == 0);
    cen  = !rand_ctrl || ($urandom_range(0, 4) != 0);
    rst2 = hold_rst;
  endtask

  task automatic check_outputs();
    int s, p, br;
    s = ticks % NS;
    p = m_phase[s];
    case (p)
      0: br = int'(ar);
      1: br = int'(d1r);
      2: br = int'(d2r);
      default: br = int'(rr) * 2 + 1;
    endcase
    check("slot", 32'(slot), 32'(s));
    check("zero", 32'(zero), 32'(s == 0));
    check("phase", 32'(phase), 32'(p));
    check("attack", 32'(attack), 32'(p == 0));
    check("eg_in", 32'(eg_in), 32'(m_level[s]));
    check("cnt_in", 32'(cnt_in), 32'(m_lsb[s]));
    check("base_rate", 32'(base_rate), 32'(br));
    check("eg_cnt", 32'(eg_cnt), 32'((ticks / (NS * ED)) % 32768));
    check("slot2", 32'(slot2), 32'(ticks2 % 2));
    check("eg_cnt2", 32'(eg_cnt2), 32'((ticks2 / 2) % 32768));
    check("phase2", 32'(phase2), 32'd3);
  endtask

  task automatic update_model();
    int s, np;
    bit ke;
    logic [9:0] nl;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_phase[i] = 3;
        m_level[i] = 10'h3FF;
        m_keyed[i] = 0;
        m_lsb[i]   = 0;
      end
      ticks = 0;
      model_valid = 1;
    end else if (cen) begin
      s  = ticks % NS;
      ke = keyon && !m_keyed[s];
      np = m_phase[s];
      nl = eg_pure;
      if (ke) begin
        np = 0;
`ifdef JT12_EG_INSTANT_ATTACK_EN
        if (ar == 5'd31) begin
          np = 1;
          nl = 10'd0;
        end
`endif
      end else if (!keyon && np != 3) np = 3;
      else if (np == 0 && eg_pure == 10'd0) np = 1;
      else if (np == 1 && int'(eg_pure[9:5]) >= slx_of(sl)) np = 2;
      m_phase[s] = np;
      m_level[s] = nl;
      m_keyed[s] = keyon;
      m_lsb[s]   = cnt_lsb;
      ticks++;
    end
    if (rst2) ticks2 = 0;
    else ticks2++;
  endtask

  task automatic step(input bit hold_rst, input bit rand_ctrl);
    @(negedge clk);
    drive_inputs(hold_rst, rand_ctrl);
    #1;
    if (model_valid) check_outputs();
    @(posedge clk);
    update_model();
  endtask

  initial begin
    ticks  = 0;
    ticks2 = 0;
    for (int i = 0; i < 32; i++) key_state[i] = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3 * NS * ED; i++) step(1'b0, 1'b0);
    while (ticks2 < 65600) step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eg_seq.md
Name: eg_seq

Overview:
- Sequential envelope-generator engine for the FM core.
- Time-multiplexed over NSLOTS operator slots; holds per-slot envelope phase, 10-bit attenuation level and counter-LSB memory.
- Maintains the global 15-bit envelope counter.
- Drives the combinational envelope-step calculator (rate/step/limit block) and writes back its result each slot cycle.

Parameters:
NSLOTS, 24, number of time-multiplexed operator slots (2..32)
EGDIV, 3, sample periods per envelope-counter increment

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cen  in  1  clock enable; one slot processed per enabled cycle
keyon  in  1  key state of the current slot
ar  in  5  attack base rate of current slot
d1r  in  5  first decay base rate
d2r  in  5  second decay base rate
rr  in  4  release rate
sl  in  4  sustain level
eg_pure  in  10  next level from step calculator
cnt_lsb  in  1  counter LSB from step calculator
slot  out  5  current slot index
zero  out  1  high while slot==0
attack  out  1  current slot is in ATTACK
base_rate  out  5  selected base rate for current slot
eg_cnt  out  15  global envelope counter
eg_in  out  10  stored level of current slot
cnt_in  out  1  stored counter LSB of current slot
phase  out  2  current slot phase (0 ATTACK, 1 DECAY1, 2 DECAY2, 3 RELEASE)

Behaviour:
- All state advances only on clk edges with cen=1; otherwise everything holds.
- Reset (rst=1 at clk edge, regardless of cen):
  - slot=0, eg_cnt=0, divider=0.
  - Every slot: level=0x3FF, phase=RELEASE, keyed=0, lsb=0.
- Slot counter: increments 0..NSLOTS-1, then wraps to 0.
  - On wrap, divider increments 0..EGDIV-1.
  - When divider wraps to 0, eg_cnt increments, modulo 2^15 (0x7FFF→0).
- Per-slot storage (phase, level, keyed, lsb) is indexed by slot.
  - eg_in, cnt_in, phase and attack are combinational reads of the current slot; the external calculator returns eg_pure/cnt_lsb in the same cycle.
  - Zero cycles of added latency.
- base_rate by phase:
  - ATTACK → ar
  - DECAY1 → d1r
  - DECAY2 → d2r
  - RELEASE → {rr,1'b1}
- Write-back at the cen edge for the current slot:
  - level←eg_pure, lsb←cnt_lsb, keyed←keyon.
- Next-phase rules, first match wins:
  1. keyon=1 and keyed=0 (key-on edge): phase←ATTACK; level←eg_pure (no forced reset).
  2. keyon=0 and phase≠RELEASE: phase←RELEASE.
  3. ATTACK and eg_pure==0: phase←DECAY1.
  4. DECAY1 and eg_pure[9:5] ≥ slx: phase←DECAY2. slx = 5'h1F if sl==4'hF, else {1'b0,sl}.
  5. Otherwise phase holds.
- DECAY2 and RELEASE are terminal; the level saturates at 0x3FF inside the calculator.
- Key-on edge and attack completion in the same cycle: key-on wins (phase stays ATTACK).
- Reset mid-attack: slot returns to RELEASE at 0x3FF; a held keyon=1 produces a fresh key-on edge on the next visit.
- Storage may be flops or distributed RAM; read must be asynchronous.

Optional Feature:
- Macro: JT12_EG_INSTANT_ATTACK_EN.
- When defined: on a key-on edge with ar==5'd31, level←0 and phase←DECAY1 in that same write-back, bypassing eg_pure.
- When undefined: a key-on edge always enters ATTACK and follows rule 1.

Test Plan:
- Reset, cen=1 for NSLOTS*EGDIV cycles → eg_cnt=1; all slots phase=3, eg_in=0x3FF, slot wrapped to 0 each NSLOTS.
- Force eg_cnt to 0x7FFF, run one divider period → eg_cnt=0.
- Slot 5: keyon 0→1, ar=31, model calculator → phase 0; after eg_pure=0, phase=1 on the next slot-5 visit.
- Slot 5 in DECAY1, sl=4, eg_pure=0x080 → phase=2; with sl=15, phase=2 only when eg_pure ≥ 0x3E0.
- Key-on edge while eg_pure=0 in ATTACK → phase stays 0; keyon low on a later visit → phase=3, base_rate={rr,1}.
- With JT12_EG_INSTANT_ATTACK_EN, key-on ar=31 → eg_in=0, phase=1 on the next visit; with ar=30 → phase=0.
